// File: rtl/xbaseband_pkg.sv
// Shared types and instruction field positions for the xbaseband command dispatcher.
package xbaseband_pkg;

  typedef enum logic [2:0] {
    XB_SETREG = 3'd0,
    XB_START  = 3'd1,
    XB_FENCE  = 3'd2
  } xb_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    ISSUE = 2'd2
  } xb_state_e;

  localparam int INSTR_W    = 32;
  localparam int CMD_W      = 64;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_W   = 3;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_W   = 7;

endpackage

// File: rtl/xbaseband_cmd_fifo.sv
// Small synchronous FIFO holding {instruction, rs1} command entries.
// Head data is read combinationally so the dispatcher can decode it in place.
module xbaseband_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         headData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign doPush   = push && !full;
  assign doPop    = pop && !empty;
  assign headData = mem[rdPtr];

  // Pointers are exactly log2(DEPTH) wide, so they wrap without explicit compare.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/xbaseband_dispatch.sv
// Decodes queued xbaseband custom instructions into config writes, engine jobs and fences,
// tracking accepted-but-unfinished engine jobs so fences and issue limits are exact.
module xbaseband_dispatch
  import xbaseband_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUT    = 2,
  parameter int NUM_CFG    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    xbaseband_cmd_valid,
  output logic                    xbaseband_cmd_ready,
  input  logic [31:0]             xbaseband_cmd_payload_instruction,
  input  logic [31:0]             xbaseband_cmd_payload_rs1,
  output logic                    eng_cmd_valid,
  input  logic                    eng_cmd_ready,
  output logic [6:0]              eng_cmd_op,
  output logic [31:0]             eng_cmd_arg,
  input  logic                    eng_done,
  output logic [32*NUM_CFG-1:0]   cfg_regs,
  output logic                    busy,
  output logic                    err_illegal,
  output logic                    err_underflow,
  input  logic                    err_clear
);

  localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int               OUT_W     = $clog2(MAX_OUT + 1);
  localparam logic [OUT_W-1:0] MAX_OUT_V = OUT_W'(MAX_OUT);
  localparam logic [7:0]       CFG_MASK  = 8'((1 << NUM_CFG) - 1);

  xb_state_e          state;
  xb_state_e          nextState;
  logic [CMD_W-1:0]   headData;
  logic [INSTR_W-1:0] headInstr;
  logic [31:0]        headRs1;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [2:0]         cfgIdx;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [CNT_W-1:0]   fifoCount;
  logic [OUT_W-1:0]   outstanding;
  logic [31:0]        cfgReg [NUM_CFG];
  logic               decSetreg;
  logic               decStart;
  logic               decFence;
  logic               canIssue;
  logic               noneOutstanding;
  logic               popHead;
  logic               cfgWrite;
  logic               loadJob;
  logic               setIllegal;
  logic               engAccept;
  logic               unusedInstrBits;

  xbaseband_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) cmdFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (xbaseband_cmd_valid),
    .pushData ({xbaseband_cmd_payload_instruction, xbaseband_cmd_payload_rs1}),
    .pop      (popHead),
    .headData (headData),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  assign xbaseband_cmd_ready = !fifoFull;
  assign headInstr = headData[CMD_W-1 -: INSTR_W];
  assign headRs1   = headData[31:0];
  assign funct3    = headInstr[FUNCT3_LSB +: FUNCT3_W];
  assign funct7    = headInstr[FUNCT7_LSB +: FUNCT7_W];
  assign cfgIdx    = funct7[2:0];
  assign unusedInstrBits = ^{headInstr[FUNCT7_LSB-1:FUNCT3_LSB+FUNCT3_W],
                             headInstr[FUNCT3_LSB-1:0]};

  // A SETREG aimed past the implemented registers falls through to the illegal path.
  assign decSetreg       = (funct3 == XB_SETREG) && CFG_MASK[cfgIdx];
  assign decStart        = (funct3 == XB_START);
  assign decFence        = (funct3 == XB_FENCE);
  assign canIssue        = (outstanding < MAX_OUT_V);
  assign noneOutstanding = (outstanding == '0);
  assign engAccept       = eng_cmd_valid && eng_cmd_ready;
  assign busy = (fifoCount != '0) || !noneOutstanding || (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (!fifoEmpty) nextState = EXEC;
      EXEC: begin
        if (decSetreg)      nextState = IDLE;
        else if (decStart)  nextState = canIssue ? ISSUE : EXEC;
        else if (decFence)  nextState = noneOutstanding ? IDLE : EXEC;
        else                nextState = IDLE;
      end
      ISSUE: if (eng_cmd_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    popHead    = 1'b0;
    cfgWrite   = 1'b0;
    loadJob    = 1'b0;
    setIllegal = 1'b0;
    if (state == EXEC) begin
      if (decSetreg) begin
        cfgWrite = 1'b1;
        popHead  = 1'b1;
      end else if (decStart) begin
        loadJob = canIssue;
        popHead = canIssue;
      end else if (decFence) begin
        popHead = noneOutstanding;
      end else begin
        setIllegal = 1'b1;
        popHead    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CFG; i++) cfgReg[i] <= '0;
    end else if (cfgWrite) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        if (cfgIdx == 3'(i)) cfgReg[i] <= headRs1;
      end
    end
  end

  // Op/arg keep their last value after the handshake; only valid drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_cmd_valid <= 1'b0;
      eng_cmd_op    <= '0;
      eng_cmd_arg   <= '0;
    end else if (loadJob) begin
      eng_cmd_valid <= 1'b1;
      eng_cmd_op    <= funct7;
      eng_cmd_arg   <= headRs1;
    end else if ((state == ISSUE) && eng_cmd_ready) begin
      eng_cmd_valid <= 1'b0;
    end
  end

  // A done with nothing outstanding is flagged and ignored rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
    end else begin
      case ({engAccept, eng_done && !noneOutstanding})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_illegal   <= 1'b0;
      err_underflow <= 1'b0;
    end else if (err_clear) begin
      err_illegal   <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (setIllegal)                  err_illegal   <= 1'b1;
      if (eng_done && noneOutstanding) err_underflow <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CFG; g++) begin : gCfgOut
    assign cfg_regs[32*g +: 32] = cfgReg[g];
  end

endmodule
